// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS multiply/divide unit with HI/LO register pair.
// Ports: clk, rst (async, active-high); start_i, op_i (00 MULT, 01 MULTU,
// 10 DIV, 11 DIVU), a_i/b_i operands; we_hi_i/we_lo_i/wd_i MTHI/MTLO writes;
// busy_o to the hazard unit; done_o result pulse; hi_o/lo_o register reads.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             we_hi_i,
  input  logic             we_lo_i,
  input  logic [WIDTH-1:0] wd_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dv_q, hi_q, lo_q;
  logic div_q, qneg_q, rneg_q, dz_q, done_q;
  logic sa, sb, last;
  logic [WIDTH-1:0] mag_a, mag_b, res_hi, res_lo;
  logic [WIDTH:0] trial, diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
`ifndef MULDIV_FAST_MUL_EN
  logic [WIDTH:0] mul_sum;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = start_i ? (op_i[1] ? DIV : MUL) : IDLE;
`ifdef MULDIV_FAST_MUL_EN
      MUL:  state_d = FIX;
`else
      MUL:  state_d = last ? FIX : MUL;
`endif
      DIV:  state_d = last ? FIX : DIV;
      FIX:  state_d = IDLE;
    endcase
  end
  always_comb begin
    sa = ~op_i[0] & a_i[WIDTH-1];
    sb = ~op_i[0] & b_i[WIDTH-1];
    mag_a = sa ? -a_i : a_i;
    mag_b = sb ? -b_i : b_i;
    last = cnt_q == CW'(WIDTH - 1);
`ifndef MULDIV_FAST_MUL_EN
    mul_sum = {1'b0, rem_q} + (quo_q[0] ? {1'b0, dv_q} : '0);
`endif
    // Restoring step: one extra bit so the trial subtract never wraps.
    trial = {rem_q, quo_q[WIDTH-1]};
    diff = trial - {1'b0, dv_q};
    prod = {rem_q, quo_q};
    prod_fix = qneg_q ? -prod : prod;
    res_hi = div_q ? (rneg_q ? -rem_q : rem_q) : prod_fix[2*WIDTH-1:WIDTH];
    // Divide by zero: remainder already equals a after sign fix; force LO to -1.
    res_lo = div_q ? (dz_q ? '1 : (qneg_q ? -quo_q : quo_q)) : prod_fix[WIDTH-1:0];
    busy_o = state_q != IDLE;
    done_o = done_q;
    hi_o = hi_q;
    lo_o = lo_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dv_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      div_q <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      dz_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= state_q == FIX;
      unique case (state_q)
        IDLE:
          if (start_i) begin
            // Multiply: dv holds multiplicand, quo the shifting multiplier.
            // Divide: dv holds divisor, quo the shifting dividend.
            dv_q <= op_i[1] ? mag_b : mag_a;
            quo_q <= op_i[1] ? mag_a : mag_b;
            rem_q <= '0;
            cnt_q <= '0;
            div_q <= op_i[1];
            qneg_q <= sa ^ sb;
            rneg_q <= sa;
            dz_q <= b_i == '0;
          end else begin
            if (we_hi_i) hi_q <= wd_i;
            if (we_lo_i) lo_q <= wd_i;
          end
        MUL: begin
`ifdef MULDIV_FAST_MUL_EN
          {rem_q, quo_q} <= {{WIDTH{1'b0}}, dv_q} * {{WIDTH{1'b0}}, quo_q};
`else
          {rem_q, quo_q} <= {mul_sum, quo_q[WIDTH-1:1]};
          cnt_q <= cnt_q + CW'(1);
`endif
        end
        DIV: begin
          rem_q <= diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
          quo_q <= {quo_q[WIDTH-2:0], ~diff[WIDTH]};
          cnt_q <= cnt_q + CW'(1);
        end
        FIX: begin
          hi_q <= res_hi;
          lo_q <= res_lo;
        end
      endcase
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized scoreboard bench for muldiv_unit.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst, start, we_hi, we_lo, busy, done;
  logic [1:0] op;
  logic [31:0] a, b, wd, hi, lo, hold;
  logic [63:0] mon_e;
  logic [63:0] exp_q[$];
  int checks = 0, errors = 0;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 33;
`endif
  always #5 clk = ~clk;
  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
    .we_hi_i(we_hi), .we_lo_i(we_lo), .wd_i(wd),
    .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo)
  );
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint ux = longint'({32'b0, x});
    longint uy = longint'({32'b0, y});
    if (o == 2'd0) return 64'(sx * sy);
    if (o == 2'd1) return 64'(ux * uy);
    if (y == 32'd0) return {x, 32'hFFFFFFFF};
    if (o == 2'd2) return {32'(sx % sy), 32'(sx / sy)};
    return {32'(ux % uy), 32'(ux / uy)};
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done actual=1 required=0");
      end else begin
        mon_e = exp_q.pop_front();
        chk("result", {hi, lo}, mon_e);
      end
    end
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit poke);
    int n;
    start = 1'b1; op = o; a = x; b = y;
    exp_q.push_back(model(o, x, y));
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (poke && n == 1) begin
        start = 1'b1; we_hi = 1'b1; wd = $urandom; op = 2'($urandom);
      end else begin
        start = 1'b0; we_hi = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0; we_hi = 1'b0;
    chk("busy_len", 64'(n), o[1] ? 64'd33 : 64'(MUL_LAT));
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int n;
    logic [31:0] rb;
    rst = 1'b1; start = 1'b0; we_hi = 1'b0; we_lo = 1'b0; op = 2'd0; a = '0; b = '0; wd = '0;
    repeat (2) @(negedge clk);
    chk("reset_state", {30'd0, busy, done, hi, lo}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    do_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    chk("multu_max", {hi, lo}, 64'hFFFFFFFE_00000001);
    do_op(2'd0, 32'hFFFFFFFD, 32'd7, 0);
    chk("mult_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
    do_op(2'd2, 32'hFFFFFFF9, 32'd2, 0);
    chk("div_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    do_op(2'd3, 32'd100, 32'd0, 0);
    chk("divu_zero", {hi, lo}, 64'h00000064_FFFFFFFF);
    do_op(2'd2, 32'hFFFFFF9C, 32'd0, 0);
    chk("div_zero_signed", {hi, lo}, 64'hFFFFFF9C_FFFFFFFF);
    do_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 0);
    chk("div_ovf", {hi, lo}, 64'h00000000_80000000);
    do_op(2'd0, 32'd12345, 32'hFFFF0000, 1);
    do_op(2'd2, 32'd1000, 32'd7, 1);
    chk("poke_div", {hi, lo}, {32'd6, 32'd142});
    we_lo = 1'b1; wd = 32'h1234; hold = hi;
    @(negedge clk);
    we_lo = 1'b0;
    chk("mtlo", {hi, lo}, {hold, 32'h1234});
    we_hi = 1'b1; we_lo = 1'b1; wd = 32'hCAFEF00D;
    @(negedge clk);
    we_hi = 1'b0; we_lo = 1'b0;
    chk("mthi_mtlo_both", {hi, lo}, {2{32'hCAFEF00D}});
    start = 1'b1; op = 2'd3; a = 32'd9; b = 32'd4; we_hi = 1'b1; wd = 32'hDEADBEEF;
    exp_q.push_back(model(2'd3, 32'd9, 32'd4));
    @(negedge clk);
    start = 1'b0; we_hi = 1'b0;
    chk("start_wins", {hi, lo}, {2{32'hCAFEF00D}});
    wait_idle(n);
    chk("busy_len_sw", 64'(n), 64'd33);
    for (int i = 0; i < 30; i++) begin
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : $urandom_range(1, 255));
      do_op(2'($urandom), $urandom, rb, $urandom_range(0, 3) == 0);
    end
    start = 1'b1; op = 2'd2; a = $urandom; b = $urandom_range(1, 1000);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_op", {30'd0, busy, done, hi, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("idle_after_rst", {63'd0, busy}, 64'd0);
    do_op(2'd3, 32'd9, 32'd4, 0);
    chk("divu_after_rst", {hi, lo}, {32'd1, 32'd2});
    @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with the HI/LO register pair for the MIPS EX stage. It accepts MULT/MULTU/DIV/DIVU from EX, runs a multi-cycle state machine, and drives `busy` back to the hazard unit. While `busy` is high, the hazard unit holds any later MFHI/MFLO/MTHI/MTLO or mul/div instruction with stall_f/stall_d/flush_e. HI/LO read ports feed the EX-stage result mux.

## Interface
- `WIDTH`, 32, operand and HI/LO width; iteration count equals WIDTH
- `clk`  in  1  pipeline clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  EX holds a valid mul/div instruction that is not being flushed
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- `a`  in  WIDTH  rs operand (forwarded value)
- `b`  in  WIDTH  rt operand (forwarded value)
- `we_hi`  in  1  MTHI write strobe
- `we_lo`  in  1  MTLO write strobe
- `wd`  in  WIDTH  MTHI/MTLO data
- `busy`  out  1  registered; high when state ≠ IDLE; goes to the hazard unit
- `done`  out  1  registered one-cycle pulse when HI/LO receive a mul/div result
- `hi`  out  WIDTH  HI register
- `lo`  out  WIDTH  LO register

## Operation
- States: IDLE, MUL, DIV, FIX.
- **IDLE**
  - `start` latches operands and computes magnitudes for signed ops.
  - Sign bits are captured: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
  - Iteration counter is cleared.
  - Next state is MUL for op[1]=0, DIV for op[1]=1.
- **MUL:** shift-add, one multiplier bit per cycle, with a 2·WIDTH accumulator. After WIDTH cycles, go to FIX.
- **DIV:** restoring division, one quotient bit per cycle. After WIDTH cycles, go to FIX.
- **FIX:** apply two's-complement sign correction, write {HI,LO}, go to IDLE.
- Results:
  - MULT/MULTU: HI = upper product word, LO = lower product word.
  - DIV/DIVU: LO = quotient, HI = remainder.
- Divide by zero:
  - The operation still runs full length.
  - Result is HI = a, LO = all-ones (−1), regardless of signedness.
- Signed DIV of 0x80000000 by 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- `start` while busy is ignored; the operation in flight is unaffected.
- `we_hi`/`we_lo`:
  - Honoured only in IDLE with `start` low; otherwise dropped.
  - `start` wins over a same-cycle write.
  - Both strobes high writes `wd` to both registers.
- Internal arithmetic is at least WIDTH+1 bits for the restoring subtract; no truncation before FIX.

## Timing
- Reset: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter 0. Reset mid-operation abandons the operation immediately; HI/LO return to 0.
- Cycle 0 (`start` sampled at an edge):
  - `busy` rises after that edge.
  - `busy` stays high for WIDTH+1 cycles (WIDTH compute + 1 FIX).
- HI/LO update at the FIX→IDLE edge. In that same cycle `busy`=0 and `done`=1.
- Back-to-back: a new `start` is accepted in the first cycle `busy` is low (same cycle as `done`).
- Reads (`hi`,`lo`) are combinational from the registers. MTHI/MTLO data is visible the cycle after the strobe.
- Default WIDTH=32: total latency is 33 busy cycles for both multiply and divide.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MUL completes in one cycle using a full-width combinational multiplier.
  - Multiply `busy` lasts 2 cycles (MUL + FIX).
  - Divide is unchanged.
- Undefined: iterative multiply as above, with no wide multiplier inferred.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → after 33 busy cycles, HI=0xFFFFFFFE, LO=0x00000001, `done` pulse once.
- MULT a=0xFFFFFFFD (−3), b=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB; with `MULDIV_FAST_MUL_EN`, `busy` high exactly 2 cycles.
- DIV a=0xFFFFFFF9 (−7), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU a=100, b=0 → LO=0xFFFFFFFF, HI=100.
- Operation in flight, pulse `start` with new operands and `we_hi`=1 mid-busy → result unchanged, HI not overwritten; MTLO 0x1234 in IDLE → LO=0x1234 next cycle.
- DIV started, `rst` asserted at busy cycle 10 → `busy`=0, `hi`=`lo`=0 immediately, no `done`; a fresh DIVU 9/4 then gives LO=2, HI=1.
